// File: rtl/conv_pkg.sv
// conv_pkg: shared conv-stage image dims, kernel size and output-map sizing helpers
package conv_pkg;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int K_DEF = 3;
  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction
  function automatic int bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_axis_cnt.sv
// conv_axis_cnt: one raster axis position plus stride phase, flags window-aligned positions and wrap
module conv_axis_cnt
  import conv_pkg::*;
#(
  parameter int N      = IMG_W_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic win_o,
  output logic wrap_o
);
  localparam int PW = bits(N);
  localparam int SW = bits(STRIDE);
  logic [PW-1:0] pos_q, pos_d;
  logic [SW-1:0] ph_q, ph_d;
  logic at_end, in_win;
  assign at_end = pos_q == PW'(N - 1);
  assign in_win = pos_q >= PW'(K - 1);
  assign win_o  = in_win & (ph_q == '0);
  assign wrap_o = en_i & at_end;
  // phase only starts turning once a full kernel span has been seen on this axis
  always_comb begin
    pos_d = clr_i ? '0 : !en_i ? pos_q : at_end ? '0 : pos_q + 1'b1;
    ph_d  = (clr_i || (en_i && at_end)) ? '0 :
            (en_i && in_win) ? ((ph_q == SW'(STRIDE - 1)) ? '0 : ph_q + 1'b1) : ph_q;
  end
  // position and phase registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_q <= '0;
      ph_q  <= '0;
    end else begin
      pos_q <= pos_d;
      ph_q  <= ph_d;
    end
endmodule

// File: rtl/conv_rc_cnt.sv
// conv_rc_cnt: raster row/column tracker marking pixels that complete a strided KxK window
module conv_rc_cnt
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = 1,
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE),
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE),
  localparam int CW    = bits(OUT_W),
  localparam int RW    = bits(OUT_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_vld,
  output logic          out_vld_rc,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          frame_done,
  output logic          busy
);
  logic col_win, col_wrap, row_win, row_wrap;
  logic hit, last, ocol_wrap;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [RW-1:0] orow_q, orow_d;
  logic vld_q, done_q, busy_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  conv_axis_cnt #(.N(IMG_W), .K(K), .STRIDE(STRIDE)) u_col (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(in_vld), .win_o(col_win), .wrap_o(col_wrap)
  );
  conv_axis_cnt #(.N(IMG_H), .K(K), .STRIDE(STRIDE)) u_row (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(col_wrap), .win_o(row_win), .wrap_o(row_wrap)
  );
  assign hit       = in_vld & col_win & row_win;
  assign last      = row_wrap;
  assign ocol_wrap = ocol_q == CW'(OUT_W - 1);
  // output-map coordinates advance once per window hit
  always_comb begin
    ocol_d = clr ? '0 : !hit ? ocol_q : ocol_wrap ? '0 : ocol_q + 1'b1;
    orow_d = clr ? '0 : !(hit && ocol_wrap) ? orow_q : (orow_q == RW'(OUT_H - 1)) ? '0 : orow_q + 1'b1;
  end
  // registered outputs, one cycle behind the accepted pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ocol_q <= '0;
      orow_q <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      vld_q  <= hit & ~clr;
      done_q <= last & ~clr;
      busy_q <= clr ? 1'b0 : in_vld ? ~last : busy_q;
      if (hit && !clr) begin
        row_q <= orow_q;
        col_q <= ocol_q;
      end
    end
  assign out_vld_rc = vld_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
endmodule
